// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared state encoding and operation constants for the mul/div unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] CALC = 2'd1;
    localparam logic [STATE_W-1:0] FIX  = 2'd2;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Sliced to WIDTH by the user, so WIDTH may not exceed 64.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
// ============================================================================
// Module : muldiv_sign_fix
// Brief  : Conditional two's-complement negate (magnitude on entry, sign on exit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (-val) : val;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO.
//          Optional macro MULDIV_EARLY_OUT_EN: zero-operand multiply and
//          zero-divisor divide skip the iteration phase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mul0_div1_sel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 w_go;
    logic                 w_early;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix, w_rem_fix;
    logic [WIDTH:0]       w_sum, w_trial;
    logic [2*WIDTH-1:0]   w_mul_step, w_div_step;

    assign w_go = start && !abort;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = (mul0_div1_sel == OP_MUL) ? ((op_a == '0) || (op_b == '0))
                                               : (op_b == '0);
`else
    assign w_early = 1'b0;
`endif

    muldiv_sign_fix #(.W(WIDTH)) u_mag_a (
        .val(op_a), .neg(is_signed & op_a[WIDTH-1]), .res(w_a_mag));
    muldiv_sign_fix #(.W(WIDTH)) u_mag_b (
        .val(op_b), .neg(is_signed & op_b[WIDTH-1]), .res(w_b_mag));
    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .val(acc_q), .neg(neg_q), .res(w_prod_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_quot (
        .val(acc_q[WIDTH-1:0]), .neg(neg_q), .res(w_quot_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val(acc_q[2*WIDTH-1:WIDTH]), .neg(rneg_q), .res(w_rem_fix));

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_step = {w_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}.
    assign w_trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    assign w_div_step = w_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            opnd_q  <= '0;
            a_raw_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            opnd_q  <= opnd_d;
            a_raw_q <= a_raw_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_go) state_d = w_early ? FIX : CALC;
            CALC: begin
                if (abort)                             state_d = IDLE;
                else if (cnt_q == CNT_W'(WIDTH - 1))   state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        opnd_d  = opnd_q;
        a_raw_d = a_raw_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_go) begin
                    op_d    = mul0_div1_sel;
                    neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    rneg_d  = is_signed & op_a[WIDTH-1];
                    div0_d  = (mul0_div1_sel == OP_DIV) && (op_b == '0);
                    a_raw_d = op_a;
                    cnt_d   = '0;
                    if (mul0_div1_sel == OP_DIV) begin
                        opnd_d = w_b_mag;
                        acc_d  = {{WIDTH{1'b0}}, w_a_mag};
                    end else begin
                        opnd_d = w_a_mag;
                        // A skipped multiply must still present a zero product in FIX.
                        acc_d  = w_early ? '0 : {{WIDTH{1'b0}}, w_b_mag};
                    end
                end
            end
            CALC: begin
                if (!abort) begin
                    acc_d = (op_q == OP_DIV) ? w_div_step : w_mul_step;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                if (!abort) begin
                    done_d = 1'b1;
                    if (op_q == OP_MUL) begin
                        {hi_d, lo_d} = w_prod_fix;
                    end else if (div0_q) begin
                        lo_d = DIV0_QUOT[WIDTH-1:0];
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = w_quot_fix;
                        hi_d = w_rem_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Directed-vector self-checking bench for muldiv_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             sel = 1'b0;
    logic             sgn = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .mul0_div1_sel(sel),
        .is_signed(sgn), .op_a(op_a), .op_b(op_b), .abort(abort),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one op, scrambles the inputs after capture, and optionally
    // re-pulses start spur_at cycles in to confirm it is ignored.
    task automatic run_op(input string tag, input logic s, input logic g,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo,
                          input int elat, input int spur_at);
        int lat  = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1; sel = s; sgn = g; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; sel = ~s; sgn = ~g; op_a = ~a; op_b = ~b;
        if (busy) bcnt++;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
            if (lat == spur_at) begin
                start = 1'b1; sel = 1'b1; sgn = 1'b0; op_a = 32'd1000; op_b = 32'd3;
            end
        end
        start = 1'b0;
        check({tag, " done"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " busy cycles"}, 64'(bcnt), 64'(elat));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
        @(posedge clk); #1;
        check({tag, " done pulse width"}, 64'(done), 64'd0);
        check({tag, " hi hold"}, 64'(hi), 64'(ehi));
    endtask

    initial begin
        int div0_lat;
        bit got_done;
`ifdef MULDIV_EARLY_OUT_EN
        div0_lat = 1;
`else
        div0_lat = WIDTH + 1;
`endif

        #2 rst = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op("MULT -3*5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, -1);
        run_op("MULTU max*max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, -1);
        run_op("DIV -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1);
        run_op("DIV 7/-2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, -1);
        run_op("DIVU 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, -1);
        run_op("DIVU 100/0", 1'b1, 1'b0, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, div0_lat, -1);
        run_op("DIV ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, -1);

        // Abort at cycle 10 of a MULT: no done, hi/lo keep the overflow result.
        @(negedge clk);
        start = 1'b1; sel = 1'b0; sgn = 1'b1; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) got_done = 1'b1;
        end
        check("abort no done", 64'(got_done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'h8000_0000);

        // start and abort together in IDLE: nothing starts.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; sel = 1'b0; op_a = 32'd2; op_b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start+abort busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-CALC clears everything immediately.
        @(negedge clk);
        start = 1'b1; sel = 1'b0; sgn = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        check("async rst hi", 64'(hi), 64'd0);
        check("async rst lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op("MULTU 6*7", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 33, 5);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
